// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, small helpers.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Encoding 3 is treated like NONE.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } uart_parity_e;

    function automatic logic parity_on(input logic [1:0] mode);
        return (mode == EVEN) || (mode == ODD);
    endfunction

endpackage

// File: rtl/baud_cnt.sv
// Loadable baud down-counter; tick is high while the count sits at zero.
// Latency: load takes effect next cycle; tick is combinational from the count.
// Backpressure: none; reloads from reload_val on every zero while run is high.
//
// Ports: clk, rstn (async active-low), run (frame active), load/load_val
// (start a new frame), reload_val (latched period for subsequent bits), tick.
module baud_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         run,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] reload_val,
    output logic         tick
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (!run) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            cnt <= reload_val;
        end else begin
            cnt <= cnt - W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining a first-word-fall-through FIFO onto a serial line.
// Latency: pop in cycle T, start bit on tx from T+1; back-to-back frames with no gap.
// Backpressure: pops only when en is high, FIFO non-empty and the line is idle/finishing.
//
// Ports: clk, rstn (async active-low); en gates new pops; div/parity/stop2 frame
// config latched at each pop; fifo_dout/fifo_empty FIFO head; fifo_r pop strobe;
// tx serial out (idle high); busy frame in progress; done last cycle of a frame.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic [DIV_BITS-1:0]  div,
    input  logic [1:0]           parity,
    input  logic                 stop2,
    input  logic [DATA_BITS-1:0] fifo_dout,
    input  logic                 fifo_empty,
    output logic                 fifo_r,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    uart_state_e           state;
    logic [DATA_BITS-1:0]  shift;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  par_acc;
    logic [DIV_BITS-1:0]   cfg_div;
    logic [1:0]            cfg_parity;
    logic                  cfg_stop2;
    logic                  tick;
    logic                  last_stop;

    // The bit counter doubles as the stop-bit index once in STOP.
    assign last_stop = (state == STOP) && tick && (bit_cnt == CNT_W'(cfg_stop2));
    assign done      = last_stop;
    assign fifo_r    = rstn && en && !fifo_empty && ((state == IDLE) || last_stop);

    // First bit period of a frame comes from the live div input (config is
    // being latched in the same cycle); later periods reload from cfg_div.
    baud_cnt #(
        .W (DIV_BITS)
    ) u_baud (
        .clk        (clk),
        .rstn       (rstn),
        .run        (state != IDLE),
        .load       (fifo_r),
        .load_val   (div),
        .reload_val (cfg_div),
        .tick       (tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            par_acc    <= 1'b0;
            cfg_div    <= '0;
            cfg_parity <= 2'd0;
            cfg_stop2  <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
        end else if (fifo_r) begin
            state      <= START;
            shift      <= fifo_dout;
            bit_cnt    <= '0;
            par_acc    <= 1'b0;
            cfg_div    <= div;
            cfg_parity <= parity;
            cfg_stop2  <= stop2;
            tx         <= 1'b0;
            busy       <= 1'b1;
        end else if (tick) begin
            case (state)
                START: begin
                    state <= DATA;
                    tx    <= shift[0];
                end
                DATA: begin
                    shift   <= shift >> 1;
                    par_acc <= par_acc ^ shift[0];
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        if (parity_on(cfg_parity)) begin
                            state <= PARITY;
                            // Include the bit leaving now; the accumulator lags by one.
                            tx    <= par_acc ^ shift[0] ^ (cfg_parity == ODD);
                        end else begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        tx      <= shift[1];
                    end
                end
                PARITY: begin
                    state <= STOP;
                    tx    <= 1'b1;
                end
                STOP: begin
                    if (last_stop) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        busy    <= 1'b0;
                        tx      <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int DB = 8;
    localparam int DW = 16;
    localparam int TRACE = 300;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic [DW-1:0] div;
    logic [1:0]    parity;
    logic          stop2;
    logic [DB-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_r;
    logic          tx;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    uart_tx #(
        .DATA_BITS (DB),
        .DIV_BITS  (DW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .div        (div),
        .parity     (parity),
        .stop2      (stop2),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_r     (fifo_r),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [7:0] word;
        int         dv;
        int         par;
        bit         st2;
        int         exp_len;
        int         exp_pbit;   // -1: no parity bit in frame
    } vec_t;

    vec_t       vecs [7];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] fq [$];
    logic       tr_tx   [0:TRACE-1];
    logic       tr_busy [0:TRACE-1];
    logic       tr_done [0:TRACE-1];
    logic       tr_fr   [0:TRACE-1];
    int         tidx;
    logic       s_fr;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    // One clock: sample outputs at the falling edge, then model the FIFO pop
    // just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (tidx < TRACE) begin
            tr_tx[tidx]   = tx;
            tr_busy[tidx] = busy;
            tr_done[tidx] = done;
            tr_fr[tidx]   = fifo_r;
        end
        s_fr = fifo_r;
        tidx++;
        @(posedge clk);
        #1;
        if (s_fr && fq.size() != 0) void'(fq.pop_front());
        drive_fifo();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Expected line level i cycles after the pop cycle (pop = cycle 0).
    function automatic logic ref_tx(input logic [7:0] w, input int dv, input int par,
                                    input bit st2, input int i);
        int  p;
        int  len;
        int  b;
        p   = (par == 1 || par == 2) ? 1 : 0;
        len = (10 + p + (st2 ? 1 : 0)) * (dv + 1);
        if (i < 1 || i > len) return 1'b1;
        b = (i - 1) / (dv + 1);
        if (b == 0) return 1'b0;
        if (b <= 8) return w[b-1];
        if (p == 1 && b == 9) return (^w) ^ (par == 2);
        return 1'b1;
    endfunction

    function automatic int tx_mism(input logic [7:0] w, input int dv, input int par,
                                   input bit st2, input int a, input int b, input int off);
        int c = 0;
        for (int i = a; i <= b; i++)
            if (tr_tx[i] !== ref_tx(w, dv, par, st2, i - off)) c++;
        return c;
    endfunction

    // sel: 0 tx, 1 busy, 2 done, 3 fifo_r
    function automatic int cnt_tr(input int sel, input int a, input int b, input logic val);
        int  c = 0;
        logic s;
        for (int i = a; i <= b; i++) begin
            case (sel)
                0:       s = tr_tx[i];
                1:       s = tr_busy[i];
                2:       s = tr_done[i];
                default: s = tr_fr[i];
            endcase
            if (s === val) c++;
        end
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int dpos;

        vecs[0] = '{8'hA5, 3, 0, 1'b0, 40, -1};
        vecs[1] = '{8'h07, 0, 1, 1'b0, 11,  1};
        vecs[2] = '{8'h07, 0, 2, 1'b0, 11,  0};
        vecs[3] = '{8'h07, 0, 1, 1'b1, 12,  1};
        vecs[4] = '{8'h3C, 1, 2, 1'b1, 24,  1};
        vecs[5] = '{8'hFF, 2, 3, 1'b0, 30, -1};
        vecs[6] = '{8'h00, 0, 1, 1'b1, 12,  0};

        // Reset: outputs idle and no pop even with data available and en high.
        tidx   = 0;
        rstn   = 1'b0;
        en     = 1'b1;
        div    = 16'd3;
        parity = 2'd0;
        stop2  = 1'b0;
        fq.push_back(8'h11);
        drive_fifo();
        @(negedge clk);
        @(negedge clk);
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset fifo_r", fifo_r, 0);
        fq.delete();
        drive_fifo();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        run(3);
        check("idle empty fifo_r", cnt_tr(3, 0, 2, 1'b1), 0);

        // Table-driven single frames.
        for (int v = 0; v < 7; v++) begin
            div    = DW'(vecs[v].dv);
            parity = 2'(vecs[v].par);
            stop2  = vecs[v].st2;
            len    = vecs[v].exp_len;
            fq.push_back(vecs[v].word);
            drive_fifo();
            tidx = 0;
            run(len + 4);
            check($sformatf("v%0d tx_mismatch", v),
                  tx_mism(vecs[v].word, vecs[v].dv, vecs[v].par, vecs[v].st2, 0, len + 3, 0), 0);
            check($sformatf("v%0d busy_len", v), cnt_tr(1, 0, len + 3, 1'b1), len);
            dpos = -1;
            for (int i = 0; i <= len + 3; i++) if (tr_done[i] === 1'b1) dpos = i;
            check($sformatf("v%0d done_pos", v), dpos, len);
            check($sformatf("v%0d done_cnt", v), cnt_tr(2, 0, len + 3, 1'b1), 1);
            check($sformatf("v%0d fifo_r_cnt", v), cnt_tr(3, 0, len + 3, 1'b1), 1);
            check($sformatf("v%0d fifo_r_at0", v), tr_fr[0], 1);
            if (vecs[v].exp_pbit >= 0)
                check($sformatf("v%0d parity_bit", v), tr_tx[1 + 9 * (vecs[v].dv + 1)], vecs[v].exp_pbit);
        end

        // Back-to-back frames.
        div    = 16'd3;
        parity = 2'd0;
        stop2  = 1'b0;
        fq.push_back(8'hA5);
        fq.push_back(8'h5A);
        drive_fifo();
        tidx = 0;
        run(86);
        check("b2b fifo_r_cnt", cnt_tr(3, 0, 85, 1'b1), 2);
        check("b2b fifo_r_at40", tr_fr[40], 1);
        check("b2b start2_low", cnt_tr(0, 41, 44, 1'b0), 4);
        check("b2b done40", tr_done[40], 1);
        check("b2b done80", tr_done[80], 1);
        check("b2b busy41", tr_busy[41], 1);
        check("b2b busy81", tr_busy[81], 0);
        check("b2b frame1", tx_mism(8'hA5, 3, 0, 1'b0, 0, 39, 0), 0);
        check("b2b frame2", tx_mism(8'h5A, 3, 0, 1'b0, 40, 85, 40), 0);

        // Disabled: no pops, line idle.
        en = 1'b0;
        fq.push_back(8'h55);
        drive_fifo();
        tidx = 0;
        run(100);
        check("en0 fifo_r_cnt", cnt_tr(3, 0, 99, 1'b1), 0);
        check("en0 tx_low_cnt", cnt_tr(0, 0, 99, 1'b0), 0);
        check("en0 busy_cnt", cnt_tr(1, 0, 99, 1'b1), 0);

        // Enable, then drop en mid-frame: frame finishes, second word stays queued.
        fq.push_back(8'h33);
        en = 1'b1;
        drive_fifo();
        tidx = 0;
        run(10);
        en = 1'b0;
        run(50);
        check("endrop fifo_r_cnt", cnt_tr(3, 0, 59, 1'b1), 1);
        check("endrop frame", tx_mism(8'h55, 3, 0, 1'b0, 0, 59, 0), 0);
        check("endrop done40", tr_done[40], 1);
        check("endrop busy41", tr_busy[41], 0);
        check("endrop queued", fq.size(), 1);
        fq.delete();
        drive_fifo();
        en = 1'b1;

        // div changed mid-frame applies from the next frame only.
        fq.push_back(8'hA5);
        fq.push_back(8'hC3);
        drive_fifo();
        tidx = 0;
        run(12);
        div = 16'd7;
        run(130);
        check("divchg frame1", tx_mism(8'hA5, 3, 0, 1'b0, 0, 39, 0), 0);
        check("divchg done40", tr_done[40], 1);
        check("divchg fifo_r40", tr_fr[40], 1);
        check("divchg frame2", tx_mism(8'hC3, 7, 0, 1'b0, 40, 141, 40), 0);
        check("divchg done120", tr_done[120], 1);
        check("divchg busy121", tr_busy[121], 0);
        div = 16'd3;

        // Reset during DATA: immediate idle line, popped word lost, next word clean.
        fq.push_back(8'hA5);
        fq.push_back(8'h3C);
        drive_fifo();
        tidx = 0;
        run(10);
        check("rst pre tx", tx, 0);
        check("rst pre busy", busy, 1);
        rstn = 1'b0;
        #1;
        check("rst async tx", tx, 1);
        check("rst async busy", busy, 0);
        check("rst fifo_r", fifo_r, 0);
        run(3);
        check("rst queue", fq.size(), 1);
        rstn = 1'b1;
        drive_fifo();
        tidx = 0;
        run(44);
        check("rst next frame", tx_mism(8'h3C, 3, 0, 1'b0, 0, 43, 0), 0);
        check("rst next done40", tr_done[40], 1);
        check("rst next fifo_r_cnt", cnt_tr(3, 0, 43, 1'b1), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
